fetch_queue: RTL

- Consumer end of the program-counter interface.
- Takes the current PC value, issues one memory read per address over a req/ack handshake, and pulses `pc_inc` back to the PC after each accepted word.
- Buffers fetched {address, instruction} pairs in a small FIFO for the decode stage.
- Sits between the PC register, instruction memory and decode.

---
 rtl/fetch_queue.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: fetches one word per PC value over a req/ack port and queues {addr, instr} for decode.
// Optional FETCH_TIMEOUT_EN aborts a read that goes unacknowledged for TIMEOUT cycles.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_inc,
  input  logic             flush,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_addr,
  output logic             fetch_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, STEP, DRAIN} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             push, pop, abort;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fetch_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end
`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q;
  // Timer restarts on every state change, so REQ and DRAIN each get a full window.
  assign tmr_d = (state_d != state_q) ? '0 : tmr_q + 1'b1;
  assign abort = (state_q == REQ || state_q == DRAIN) && !mem_ack && tmr_q == TW'(TIMEOUT - 1);
  assign fetch_err = err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_q | abort;
    end
`else
  assign abort = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (!flush && !cnt_q[AW]) begin
        state_d = REQ;
        addr_d  = pc_in;
      end
      REQ:     state_d = mem_ack ? (flush ? IDLE : STEP) : abort ? IDLE : flush ? DRAIN : REQ;
      STEP:    state_d = IDLE;
      DRAIN:   state_d = (mem_ack || abort) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_req  = state_q == REQ || state_q == DRAIN;
    mem_addr = addr_q;
    pc_inc   = state_q == STEP;
  end
  assign push        = state_q == REQ && mem_ack && !flush;
  assign pop         = instr_valid && instr_ready;
  assign instr_valid = cnt_q != '0;
  assign instr_addr  = fifo_addr_q[rd_q];
  assign instr_data  = fifo_data_q[rd_q];
  // Flush empties the queue by snapping the read pointer onto the write pointer.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= flush ? wr_q : rd_q + AW'(pop);
      cnt_q <= flush ? '0 : cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      fifo_addr_q[wr_q] <= addr_q;
      fifo_data_q[wr_q] <= mem_data;
    end
endmodule
